instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter MEM_BYTES, default 8192: size in bytes of the target instruction memory; used for range checking.
REQ-002 Parameter MARKER, default 8'hA5: start-of-frame byte.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  incoming stream byte.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 wr_en  output  1  one-cycle word write strobe to instruction memory.
REQ-009 wr_addr  output  32  byte address of the write, always word-aligned.
REQ-010 wr_data  output  32  word to write, big-endian: first received byte goes to wr_data[31:24], stored at wr_addr.
REQ-011 busy  output  1  frame in progress; the processor is held while high.
REQ-012 done  output  1  one-cycle pulse on a successfully verified frame.
REQ-013 error  output  1  sticky frame-error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK, DONE and ERROR.
REQ-015 in_ready SHALL be 1 in every state except DONE.
REQ-016 IDLE: an accepted byte equal to MARKER goes to ADDR_HI and clears the running checksum; any other byte is discarded.
REQ-017 ADDR_HI/ADDR_LO SHALL capture the 16-bit start word index, MSB first; the byte address is the index times 4.
REQ-018 CNT_HI/CNT_LO SHALL capture the 16-bit word count, MSB first.
REQ-019 On acceptance of the CNT_LO byte: if (index+count)*4 > MEM_BYTES, go to ERROR; else if count==0, go to CHECK; else go to DATA.
REQ-020 The range check in REQ-019 SHALL use at least 19-bit arithmetic, so no overflow occurs.
REQ-021 DATA SHALL shift bytes MSB first using a 2-bit byte counter.
REQ-022 On the 4th byte of a word, the next cycle SHALL have wr_en=1, wr_addr=current address and wr_data=assembled word; the address then increments by 4.
REQ-023 DATA SHALL allow back-to-back bytes with no stall, because the write is registered.
REQ-024 After the last word's 4th byte, the FSM SHALL go to CHECK.
REQ-025 Checksum: XOR of every accepted byte after MARKER (header and data) up to, but excluding, the CHECK byte.
REQ-026 CHECK: if the accepted byte equals the checksum, go to DONE; otherwise go to ERROR.
REQ-027 Words already written are not retracted when the checksum fails.
REQ-028 DONE SHALL last exactly one cycle with done=1 and in_ready=0, then return to IDLE.
REQ-029 ERROR: error=1, and bytes are accepted and discarded.
REQ-030 In ERROR, a MARKER byte SHALL clear error and go to ADDR_HI.
REQ-031 In IDLE, a MARKER byte SHALL also clear a pending error.
REQ-032 busy SHALL be 1 in ADDR_HI through CHECK and 0 otherwise.
REQ-033 in_valid low in any state SHALL hold all state; there is no timeout.
REQ-034 wr_en SHALL never be asserted outside DATA-originated writes.
REQ-035 wr_addr SHALL never reach or exceed MEM_BYTES.

Reset
REQ-036 While reset is sampled high: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, and the checksum, counters and partial word are cleared.
REQ-037 Reset in the middle of a frame SHALL discard any partial word with no wr_en.
REQ-038 Bytes presented during reset SHALL be ignored.

Structure
REQ-039 A shared package SHALL hold the state encoding (localparams), MARKER and the default MEM_BYTES.
REQ-040 The block SHALL be one module plus one natural sub-module, word_assembler: byte shift register, byte counter and full-word strobe.
REQ-041 instruction_loader drives the write port of the instruction memory; the memory's read path is unchanged.

Verification
REQ-042 Frame A5 00 0A 00 01 20 08 00 02 xx (xx = correct XOR) -> one wr_en with wr_addr=40, wr_data=32'h20080002, then done pulse, error=0.
REQ-043 Two-word frame at index 0 with in_valid high every cycle -> wr_en at addr 0 and addr 4 with no dropped bytes, busy high throughout.
REQ-044 Same as REQ-042 with a wrong checksum byte -> word still written, error=1 and sticky, no done.
REQ-045 Header index=2047, count=2 (MEM_BYTES=8192) -> ERROR after CNT_LO, no wr_en; a following valid frame clears error.
REQ-046 Reset asserted after 2 data bytes -> no wr_en, all outputs 0; a fresh frame afterwards loads correctly.
REQ-047 Count=0 frame (A5 00 00 00 00 00) -> no writes, done pulse; non-MARKER bytes in IDLE -> ignored.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the stream-to-instruction-memory loader: state
// encoding, frame marker and default memory size.
package instruction_loader_pkg;

    localparam int         MEM_BYTES_DEF = 8192;
    localparam logic [7:0] MARKER_DEF    = 8'hA5;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ADDR_HI = 4'd1;
    localparam logic [3:0] ST_ADDR_LO = 4'd2;
    localparam logic [3:0] ST_CNT_HI  = 4'd3;
    localparam logic [3:0] ST_CNT_LO  = 4'd4;
    localparam logic [3:0] ST_DATA    = 4'd5;
    localparam logic [3:0] ST_CHECK   = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        ADDR_HI = ST_ADDR_HI,
        ADDR_LO = ST_ADDR_LO,
        CNT_HI  = ST_CNT_HI,
        CNT_LO  = ST_CNT_LO,
        DATA    = ST_DATA,
        CHECK   = ST_CHECK,
        DONE    = ST_DONE,
        ERROR   = ST_ERROR
    } state_t;

    // End byte address of the frame is computed in 19 bits: two 16-bit
    // operands summed, then scaled by 4, can never wrap.
    function automatic logic range_ok(input logic [15:0] idx,
                                      input logic [15:0] cnt,
                                      input int          mem_bytes);
        logic [18:0] end_b;
        end_b = ({3'b000, idx} + {3'b000, cnt}) << 2;
        return {13'b0, end_b} <= 32'(mem_bytes);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs four bytes MSB-first into a word; strobes on the fourth byte with
// the complete word visible combinationally so the caller can register it.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_stb_o
);
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_vld_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o     = {shift_q, byte_i};
    assign word_stb_o = byte_vld_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Framed byte-stream loader: parses marker/header/data/checksum and writes
// words into instruction memory while holding the processor busy.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int         MEM_BYTES = MEM_BYTES_DEF,
    parameter logic [7:0] MARKER    = MARKER_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    state_t      state_q;
    logic [15:0] idx_q;
    logic [7:0]  cnt_hi_q;
    logic [15:0] words_left_q;
    logic [31:0] addr_q;
    logic [7:0]  csum_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        busy_q, done_q, error_q;

    logic        acc;
    logic [15:0] cnt_full;
    logic [31:0] asm_word;
    logic        asm_stb;

    assign bus.in_ready = (state_q != DONE);
    assign acc          = bus.in_valid && bus.in_ready;
    assign cnt_full     = {cnt_hi_q, bus.in_data};

    // Restart the byte counter at the header boundary so every frame's data
    // begins on a word edge regardless of what happened before.
    word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (acc && state_q == CNT_LO),
        .byte_vld_i (acc && state_q == DATA),
        .byte_i     (bus.in_data),
        .word_o     (asm_word),
        .word_stb_o (asm_stb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            csum_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE, ERROR: begin
                    if (acc && bus.in_data == MARKER) begin
                        state_q <= ADDR_HI;
                        csum_q  <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ADDR_HI: if (acc) begin
                    idx_q[15:8] <= bus.in_data;
                    csum_q      <= csum_q ^ bus.in_data;
                    state_q     <= ADDR_LO;
                end
                ADDR_LO: if (acc) begin
                    idx_q[7:0] <= bus.in_data;
                    addr_q     <= {14'b0, idx_q[15:8], bus.in_data, 2'b00};
                    csum_q     <= csum_q ^ bus.in_data;
                    state_q    <= CNT_HI;
                end
                CNT_HI: if (acc) begin
                    cnt_hi_q <= bus.in_data;
                    csum_q   <= csum_q ^ bus.in_data;
                    state_q  <= CNT_LO;
                end
                CNT_LO: if (acc) begin
                    words_left_q <= cnt_full;
                    csum_q       <= csum_q ^ bus.in_data;
                    if (!range_ok(idx_q, cnt_full, MEM_BYTES)) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt_full == 16'd0) begin
                        state_q <= CHECK;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (acc) begin
                    csum_q <= csum_q ^ bus.in_data;
                    if (asm_stb) begin
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= addr_q;
                        wr_data_q    <= asm_word;
                        addr_q       <= addr_q + 32'd4;
                        words_left_q <= words_left_q - 16'd1;
                        if (words_left_q == 16'd1)
                            state_q <= CHECK;
                    end
                end
                CHECK: if (acc) begin
                    busy_q <= 1'b0;
                    if (bus.in_data == csum_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized frame bench with a queue scoreboard for writes and done/error events.
module tb_instruction_loader;
    localparam int         MEMB = 8192;
    localparam logic [7:0] MK   = 8'hA5;

    logic clock = 1'b0;
    logic reset;
    logic busy, done, error;
    always #5 clock = ~clock;

    instruction_loader_if bus();

    instruction_loader #(.MEM_BYTES(MEMB), .MARKER(MK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_ev[$];
    int tests = 0;
    int fails = 0;
    logic prev_err = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or event.
    always @(negedge clock) begin
        wr_t w;
        logic [7:0] ev;
        if (reset) begin
            prev_err <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr", bus.wr_addr, 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.wr_addr, w.a);
                    chk("wr_data", bus.wr_data, w.d);
                end
                chk("wr_addr_in_range", 32'(bus.wr_addr < MEMB), 32'd1);
            end
            if (done) begin
                chk("done_in_ready", 32'(bus.in_ready), 32'd0);
                ev = (exp_ev.size() == 0) ? 8'h00 : exp_ev.pop_front();
                chk("event_done", 32'(ev), 32'("D"));
            end
            if (error && !prev_err) begin
                ev = (exp_ev.size() == 0) ? 8'h00 : exp_ev.pop_front();
                chk("event_error", 32'(ev), 32'("E"));
            end
            prev_err <= error;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin @(posedge clock); #1; end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] b;
        do b = 8'($urandom); while (b == MK);
        return b;
    endfunction

    // Reference model: builds the byte stream and the expected outcome directly
    // from the frame fields.
    task automatic send_frame(input int idx, input int cnt, input logic bad,
                              input int maxgap, input logic [31:0] fixed_w);
        logic [7:0] q[$];
        logic [7:0] cs;
        logic [31:0] w;
        logic rng, exp_err;
        q.push_back(MK);
        q.push_back(8'(idx >> 8)); q.push_back(8'(idx));
        q.push_back(8'(cnt >> 8)); q.push_back(8'(cnt));
        rng = ((idx + cnt) * 4) > MEMB;
        if (!rng) begin
            for (int i = 0; i < cnt; i++) begin
                w = (fixed_w != 0) ? fixed_w : $urandom;
                for (int k = 3; k >= 0; k--) q.push_back(w[k*8 +: 8]);
                exp_wr.push_back('{a: 32'((idx + i) * 4), d: w});
            end
            cs = 8'h00;
            for (int i = 1; i < q.size(); i++) cs ^= q[i];
            q.push_back(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
        end
        exp_err = rng || bad;
        exp_ev.push_back(exp_err ? 8'("E") : 8'("D"));
        for (int k = 0; k < q.size(); k++) begin
            send_byte(q[k], $urandom_range(0, maxgap));
            if (k < q.size() - 1) chk("busy_in_frame", 32'(busy), 32'd1);
        end
        idle(3);
        chk("busy_after", 32'(busy), 32'd0);
        chk("error_after", 32'(error), 32'(exp_err));
    endtask

    initial begin
        int idx, cnt, mode;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        idle(3);
        @(negedge clock);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Non-marker bytes in IDLE are ignored.
        for (int i = 0; i < 5; i++) send_byte(junk(), 0);
        chk("idle_junk_busy", 32'(busy), 32'd0);

        send_frame(10, 1, 1'b0, 1, 32'h2008_0002);      // directed single word
        send_frame(0, 2, 1'b0, 0, 32'h0);               // back-to-back
        send_frame(10, 1, 1'b1, 1, 32'h2008_0002);      // bad checksum
        for (int i = 0; i < 4; i++) send_byte(junk(), 0);
        chk("error_sticky", 32'(error), 32'd1);
        send_frame(2047, 2, 1'b0, 0, 32'h0);            // range overflow by one word
        send_frame(2046, 2, 1'b0, 0, 32'h0);            // exactly fills memory
        send_frame(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'h0); // 19-bit range arithmetic
        send_frame(0, 0, 1'b0, 0, 32'h0);               // empty frame

        // Reset after two data bytes: nothing written, everything cleared.
        send_byte(MK, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        @(posedge clock); #1;
        bus.in_data  = MK;
        @(negedge clock);
        chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        chk("midrst_wr_data", bus.wr_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);
        chk("postrst_busy", 32'(busy), 32'd0);
        send_frame(5, 1, 1'b0, 1, 32'hCAFE_F00D);

        for (int it = 0; it < 25; it++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                idx = $urandom_range(2000, 2047);
                cnt = 2048 - idx + $urandom_range(1, 5);
            end else begin
                idx = $urandom_range(0, 2040);
                cnt = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 3) == 0)
                for (int j = 0; j < 3; j++) send_byte(junk(), $urandom_range(0, 1));
            send_frame(idx, cnt, mode == 1, $urandom_range(0, 2), 32'h0);
        end

        idle(20);
        chk("drain_writes", 32'(exp_wr.size()), 32'd0);
        chk("drain_events", 32'(exp_ev.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
